// File: rtl/ram_bank.sv
// ram_bank: DEPTH x WIDTH register file with a registered read port
// and a one-word-per-cycle zero-fill sweep triggered by clear.
module ram_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              rd,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              start;
    logic              wr_en;
    logic              rd_en;
    logic              sweep;
    logic              last;

    assign last = (cnt == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: clear starts a sweep, last word ends it
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (clear) state_nxt = CLEAR;
            CLEAR:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/enable decode; clear in IDLE masks load and rd
    always_comb begin
        busy  = 1'b0;
        sweep = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                start = clear;
                wr_en = load & ~clear;
                rd_en = rd & ~clear;
            end
            CLEAR: begin
                busy  = 1'b1;
                sweep = 1'b1;
            end
            default: ;
        endcase
    end

    // Sweep counter: zeroed on start, advances one word per sweep cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (sweep)
            cnt <= cnt + 1'b1;
    end

    // Storage: per-word enable from either the write port or the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sweep && cnt == ADDR_W'(i))
                    mem[i] <= '0;
                else if (wr_en && address == ADDR_W'(i))
                    mem[i] <= in;
            end
        end
    end

    // Read port: read-first, so out sees the pre-write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= rd_en;
            if (rd_en)
                out <= mem[address];
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: directed checks of ram_bank with WIDTH=8, DEPTH=8.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_ram_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic              rd;
    logic              clear;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              busy;

    int checks = 0;
    int errors = 0;

    ram_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .address   (address),
        .load      (load),
        .rd        (rd),
        .clear     (clear),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in      = '0;
        address = '0;
        load    = 1'b0;
        rd      = 1'b0;
        clear   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: got %h expected 00", out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_after_reset();
        address = 3'd5;
        rd      = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd5_after_reset: got %h/%b expected 00/1",
                     out, out_valid);
        end
        tick();
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd5_valid_drop: got %h/%b expected 00/0",
                     out, out_valid);
        end
    endtask

    task automatic test_write_read();
        address = 3'd3;
        in      = 8'hA5;
        load    = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr3_no_valid: got %b expected 0", out_valid);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'hA5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd3: got %h/%b expected a5/1", out, out_valid);
        end
        tick();
        checks++;
        if (out !== 8'hA5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd3_hold: got %h/%b expected a5/0",
                     out, out_valid);
        end
    endtask

    task automatic test_read_first();
        address = 3'd2;
        in      = 8'h11;
        load    = 1'b1;
        tick();
        in = 8'h22;
        rd = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (out !== 8'h11 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_first_old: got %h/%b expected 11/1",
                     out, out_valid);
        end
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h22 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_first_new: got %h/%b expected 22/1",
                     out, out_valid);
        end
    endtask

    task automatic test_clear_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            address = ADDR_W'(i);
            in      = 8'h10 + 8'(i);
            load    = 1'b1;
            tick();
        end
        load    = 1'b0;
        address = 3'd7;
        rd      = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h17 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_rd7: got %h/%b expected 17/1",
                     out, out_valid);
        end
        clear = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            load    = 1'b1;
            rd      = 1'b1;
            clear   = 1'b1;
            in      = 8'hFF;
            address = ADDR_W'(i);
            checks++;
            if (busy !== 1'b1 || out !== 8'h17 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_cycle%0d: got busy=%b out=%h v=%b expected 1/17/0",
                         i, busy, out, out_valid);
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end_busy: got %b expected 0", busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            address = ADDR_W'(i);
            rd      = 1'b1;
            tick();
            checks++;
            if (out !== 8'h00 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL cleared_rd%0d: got %h/%b expected 00/1",
                         i, out, out_valid);
            end
        end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_clear_wins();
        int n;
        address = 3'd4;
        in      = 8'h7E;
        load    = 1'b1;
        clear   = 1'b1;
        tick();
        idle_inputs();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL clear_wins_len: got %0d cycles expected %0d",
                     n, DEPTH);
        end
        address = 3'd4;
        rd      = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins_rd4: got %h/%b expected 00/1",
                     out, out_valid);
        end
    endtask

    task automatic test_reset_mid_clear();
        address = 3'd6;
        in      = 8'h5A;
        load    = 1'b1;
        tick();
        load = 1'b0;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h5A) begin
            errors++;
            $display("FAIL pre_abort_rd6: got %h expected 5a", out);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b out=%h v=%b expected 0/00/0",
                     busy, out, out_valid);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resume: got %b expected 0", busy);
        end
        address = 3'd6;
        rd      = 1'b1;
        tick();
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd6_zero: got %h/%b expected 00/1",
                     out, out_valid);
        end
        rd   = 1'b0;
        in   = 8'h3C;
        load = 1'b1;
        tick();
        load = 1'b0;
        rd   = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h3C || out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_rd6_new: got %h/%b busy=%b expected 3c/1/0",
                     out, out_valid, busy);
        end
        address = 3'd7;
        rd      = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (out !== 8'h00 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd7: got %h/%b expected 00/1",
                     out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_read_first();
        test_clear_sweep();
        test_clear_wins();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
